// File: rtl/map_pkg.sv
// map_pkg: maze geometry constants, tile-position type and the rule-generated wall map.
package map_pkg;

    localparam int TILE_SHIFT = 4;
    localparam int COLS       = 40;
    localparam int ROWS       = 30;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    typedef logic [5:0] col_t;
    typedef logic [4:0] row_t;

    typedef struct packed {
        logic in_range;
        row_t row;
        col_t col;
    } tile_pos_t;

    // Border ring plus 2x2 pillars on a 4-tile pitch, leaving 2-tile corridors.
    function automatic logic tile_is_wall(input int row, input int col);
        logic border;
        logic inner;
        logic pillar;
        border = (row == 0) || (row == ROWS - 1) || (col == 0) || (col == COLS - 1);
        inner  = (row >= 2) && (row <= ROWS - 3) && (col >= 2) && (col <= COLS - 3);
        pillar = ((row % 4) >= 2) && ((col % 4) >= 2);
        return border || (inner && pillar);
    endfunction

    function automatic logic [ROWS-1:0][COLS-1:0] build_wall_map();
        logic [ROWS-1:0][COLS-1:0] m;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m[r][c] = tile_is_wall(r, c);
        return m;
    endfunction

    localparam logic [ROWS-1:0][COLS-1:0] WALL_MAP = build_wall_map();

endpackage

// File: rtl/map_tile_decode.sv
// map_tile_decode: combinational pixel -> {in_range, row, col}, shared with the renderer.
module map_tile_decode
    import map_pkg::*;
(
    input  logic [9:0] x_i,
    input  logic [8:0] y_i,
    output tile_pos_t  pos_o
);

    always_comb begin
        pos_o.in_range = (x_i < 10'(SCREEN_W)) && (y_i < 9'(SCREEN_H));
        pos_o.col      = x_i[9:TILE_SHIFT];
        pos_o.row      = y_i[8:TILE_SHIFT];
    end

endmodule

// File: rtl/map_wall_lookup.sv
// map_wall_lookup: registered "is pixel (x,y) wall?" query; off-screen and reset read as wall.
module map_wall_lookup
    import map_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       isWall
);

    tile_pos_t pos;
    logic      is_wall_d;
    logic      is_wall_q;

    map_tile_decode u_decode (
        .x_i   (x),
        .y_i   (y),
        .pos_o (pos)
    );

    // in_range guarantees row/col index inside the map, so no X on wrapped inputs.
    always_comb is_wall_d = pos.in_range ? WALL_MAP[pos.row][pos.col] : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) is_wall_q <= 1'b1;
        else     is_wall_q <= is_wall_d;
    end

    assign isWall = is_wall_q;

endmodule

// File: tb/tb_map_wall_lookup.sv
// tb_map_wall_lookup: directed checks of the registered wall lookup.
module tb_map_wall_lookup;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x   = '0;
    logic [8:0] y   = '0;
    logic       isWall;

    int checks = 0;
    int errors = 0;

    map_wall_lookup dut (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .y      (y),
        .isWall (isWall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; x = 10'd64; y = 9'd64;
        step();
        checks++;
        if (isWall !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: isWall=%b expected=1", isWall);
        end
        rst = 1'b0;
        step();
        checks++;
        if (isWall !== 1'b0) begin
            errors++;
            $display("FAIL reset_release (64,64): isWall=%b expected=0", isWall);
        end
    endtask

    task automatic test_border_corridor();
        logic [9:0] xs [4] = '{10'd0, 10'd16, 10'd639, 10'd623};
        logic [8:0] ys [4] = '{9'd0, 9'd16, 9'd479, 9'd463};
        logic       ex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            x = xs[i]; y = ys[i];
            step();
            checks++;
            if (isWall !== ex[i]) begin
                errors++;
                $display("FAIL border (%0d,%0d): isWall=%b expected=%b", xs[i], ys[i], isWall, ex[i]);
            end
        end
    endtask

    task automatic test_pillars();
        logic [9:0] xs [10] = '{10'd32, 10'd47, 10'd48, 10'd63, 10'd64, 10'd31,
                                10'd32, 10'd560, 10'd592, 10'd608};
        logic [8:0] ys [10] = '{9'd32, 9'd47, 9'd48, 9'd63, 9'd48, 9'd40,
                                9'd447, 9'd32, 9'd32, 9'd448};
        logic       ex [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            x = xs[i]; y = ys[i];
            step();
            checks++;
            if (isWall !== ex[i]) begin
                errors++;
                $display("FAIL pillar (%0d,%0d): isWall=%b expected=%b", xs[i], ys[i], isWall, ex[i]);
            end
        end
    endtask

    task automatic test_offscreen();
        logic [9:0] xs [5] = '{10'd640, 10'd100, 10'd1023, 10'd1023, 10'd16};
        logic [8:0] ys [5] = '{9'd100, 9'd480, 9'd511, 9'd16, 9'd511};
        for (int i = 0; i < 5; i++) begin
            x = xs[i]; y = ys[i];
            step();
            checks++;
            if (isWall !== 1'b1) begin
                errors++;
                $display("FAIL offscreen (%0d,%0d): isWall=%b expected=1", xs[i], ys[i], isWall);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] xs [4] = '{10'd16, 10'd32, 10'd64, 10'd0};
        logic [8:0] ys [4] = '{9'd16, 9'd32, 9'd64, 9'd0};
        logic       ex [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        x = xs[0]; y = ys[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) begin
                x = xs[i + 1]; y = ys[i + 1];
            end
            checks++;
            if (isWall !== ex[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: isWall=%b expected=%b", i, isWall, ex[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        x = 10'd16; y = 9'd16;
        step();
        checks++;
        if (isWall !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre: isWall=%b expected=0", isWall);
        end
        x = 10'd64; y = 9'd64; rst = 1'b1;
        step();
        checks++;
        if (isWall !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: isWall=%b expected=1", isWall);
        end
        rst = 1'b0; x = 10'd16; y = 9'd100;
        step();
        checks++;
        if (isWall !== 1'b0) begin
            errors++;
            $display("FAIL mid_resume: isWall=%b expected=0", isWall);
        end
    endtask

    initial begin
        test_reset();
        test_border_corridor();
        test_pillars();
        test_offscreen();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_wall_lookup.md
Name: map_wall_lookup

Overview:
- Maze wall lookup for the Pac-Man game. Answers "is pixel (x,y) part of a wall?" for movers such as the ghost and player controllers.
- The screen is 640x480 and is divided into a 40x30 grid of 16x16-pixel tiles.
- The wall pattern is fixed and generated by rule; there is no writable memory.
- The answer is registered, with one-cycle latency.

Parameters:
- TILE_SHIFT, 4, log2 of tile edge in pixels (16 px tiles).
- COLS, 40, tile columns (screen width 640 px).
- ROWS, 30, tile rows (screen height 480 px).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- x  input  10  query pixel X, unsigned, 0..1023.
- y  input  9  query pixel Y, unsigned, 0..511.
- isWall  output  1  1 = the pixel sampled on the previous edge is wall or off-screen; registered.

Behaviour:
- Reset: when rst=1 at a rising edge, isWall <= 1. The power-up/reset state reads as "blocked", so movers stay still.
- Latency: exactly 1 cycle.
  - isWall after edge N reflects the x,y values present at edge N.
  - There is no enable and no handshake; a new query is accepted every cycle.
- Tile index: col = x >> TILE_SHIFT, row = y >> TILE_SHIFT.
- Off-screen: x >= 640 or y >= 480 -> wall (1).
  - Covers arithmetic wrap by callers, e.g. x = 0 - 1 = 1023, or y = 511.
- Border: row 0, row 29, col 0 and col 39 -> wall.
- Interior pillars: for 2 <= row <= 27 and 2 <= col <= 37, the tile is wall iff (row mod 4) is in {2,3} AND (col mod 4) is in {2,3}.
  - This gives 2x2-tile blocks separated by 2-tile corridors.
- All other tiles are corridor (0). This includes row 1, row 28, col 1, col 38, and every tile whose row or col mod 4 is 0 or 1.
- Pixel granularity: every pixel within a tile returns the same value. There is no sub-tile shaping.
- Reset mid-operation: a reset cycle forces isWall=1 for that cycle. The next non-reset edge resumes normal lookup of the current x,y; no other state exists.
- Purely combinational decode feeds a single flop. There are no latches and no X propagation on any x,y value.

Decomposition:
- Package map_pkg holds:
  - TILE_SHIFT, COLS, ROWS, SCREEN_W=640, SCREEN_H=480;
  - a constant function tile_is_wall(row, col) implementing the border/pillar rule;
  - a ROWS x COLS bit-array constant built from that function, for other consumers (e.g. a renderer).
- Optional sub-module map_tile_decode (combinational pixel -> {in_range, row, col}), shared with the video renderer.
- The wall flop stays in map_wall_lookup.

Test Plan:
- Reset: hold rst=1 with x=64,y=64 -> isWall=1. After release, one edge later isWall=0, since tile (4,4) is corridor.
- Border and corridor: (0,0) -> 1; (16,16) -> 0 (tile 1,1); (639,479) -> 1 (tile 39,29); (623,463) -> 0 (tile 38,28). Each is checked one cycle after applying it.
- Pillars and tile edges:
  - (32,32) -> 1; (47,47) -> 1; (48,48) -> 1 (tile 3,3).
  - (64,48) -> 0 (col mod 4 = 0); (31,40) -> 0 (col 1).
  - Pillar (2,2)-(3,3) spans x,y 32..63.
- Off-screen/wrap: (640,100) -> 1; (100,480) -> 1; (1023,511) -> 1; (1023,16) -> 1.
- Back-to-back pipeline: apply (16,16), (32,32), (64,64), (0,0) on consecutive cycles -> isWall sequence 0,1,0,1, each lagging by one cycle.
- Reset mid-stream: during a stream of corridor queries, assert rst for one cycle -> isWall=1 that cycle, then 0 on the following edge.
